// File: rtl/popcount_expand8.sv
// Serial unary expander: turns a 4-bit count k into an 8-bit LSB-first frame of k ones.
// Build option: define POPCOUNT_EXPAND_SAT_EN to saturate out-of-range counts to 8 (else they map to 0).
module popcount_expand8 (
    input  logic       CLK,
    input  logic       ASYNCRESETN,
    input  logic [3:0] I,
    input  logic       I_valid,
    output logic       I_ready,
    output logic       O_data,
    output logic       O_valid,
    input  logic       O_ready,
    output logic       O_last,
    output logic [7:0] T,
    output logic       err
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic logic [3:0] clamp_count(input logic [3:0] k);
`ifdef POPCOUNT_EXPAND_SAT_EN
        clamp_count = (k > 4'd8) ? 4'd8 : k;
`else
        clamp_count = (k > 4'd8) ? 4'd0 : k;
`endif
    endfunction

    function automatic logic [7:0] therm(input logic [3:0] n);
        case (n)
            4'd0:    therm = 8'h00;
            4'd1:    therm = 8'h01;
            4'd2:    therm = 8'h03;
            4'd3:    therm = 8'h07;
            4'd4:    therm = 8'h0F;
            4'd5:    therm = 8'h1F;
            4'd6:    therm = 8'h3F;
            4'd7:    therm = 8'h7F;
            4'd8:    therm = 8'hFF;
            default: therm = 8'h00;
        endcase
    endfunction

    logic [0:0] r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_bitcnt;
    logic [7:0] r_therm;
    logic       r_err;

    logic       w_busy;
    logic       w_beat;
    logic       w_last_beat;
    logic       w_accept;
    logic [7:0] w_frame;

    assign w_busy      = (r_state == ST_SHIFT);
    assign w_beat      = w_busy && O_ready;
    assign w_last_beat = w_beat && (r_bitcnt == 3'd7);
    // A new count may enter in the same cycle the previous frame's final bit leaves.
    assign I_ready     = !w_busy || w_last_beat;
    assign w_accept    = I_valid && I_ready;
    assign w_frame     = therm(clamp_count(I));

    assign O_valid = w_busy;
    assign O_data  = r_shreg[0];
    assign O_last  = w_busy && (r_bitcnt == 3'd7);
    assign T       = r_therm;
    assign err     = r_err;

    // Frame state: accept loads a new frame (priority over completion), beats shift it out.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state  <= ST_IDLE;
            r_shreg  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_therm  <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && (I > 4'd8);
            if (w_accept) begin
                r_state  <= ST_SHIFT;
                r_shreg  <= w_frame;
                r_therm  <= w_frame;
                r_bitcnt <= 3'd0;
            end else if (w_beat) begin
                r_shreg  <= {1'b0, r_shreg[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_state <= ST_SHIFT;
                end
            end else begin
                r_state <= r_state;
            end
        end
    end

endmodule

// File: tb/tb_popcount_expand8.sv
// Directed, table-driven bench for popcount_expand8 (honours POPCOUNT_EXPAND_SAT_EN if defined).
module tb_popcount_expand8;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [3:0] I;
    logic       I_valid;
    logic       I_ready;
    logic       O_data;
    logic       O_valid;
    logic       O_ready;
    logic       O_last;
    logic [7:0] T;
    logic       err;

    int checks = 0;
    int errors = 0;

`ifdef POPCOUNT_EXPAND_SAT_EN
    localparam logic [7:0] OOR_FRAME = 8'hFF;
    localparam int         OOR_K     = 8;
`else
    localparam logic [7:0] OOR_FRAME = 8'h00;
    localparam int         OOR_K     = 0;
`endif

    typedef struct {
        logic [3:0] k;
        logic [7:0] frame;
        logic       err;
        int         k_eff;
    } vec_t;

    vec_t vecs[12];

    popcount_expand8 dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I           (I),
        .I_valid     (I_valid),
        .I_ready     (I_ready),
        .O_data      (O_data),
        .O_valid     (O_valid),
        .O_ready     (O_ready),
        .O_last      (O_last),
        .T           (T),
        .err         (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer k to an idle DUT with O_ready high and walk the whole frame.
    task automatic run_frame(input logic [3:0] k, input logic [7:0] exp_frame,
                             input logic exp_err, input int exp_keff, input string tag);
        logic [7:0] got;
        int ones;
        got = 8'h00;
        O_ready = 1'b1;
        I = k;
        I_valid = 1'b1;
        #1;
        chk({tag, " ready_idle"}, 32'(I_ready), 32'd1);
        tick();
        I_valid = 1'b0;
        I = 4'hA;
        chk({tag, " err_pulse"}, 32'(err), 32'(exp_err));
        chk({tag, " T"}, 32'(T), 32'(exp_frame));
        for (int j = 0; j < 8; j++) begin
            chk({tag, " valid"}, 32'(O_valid), 32'd1);
            chk({tag, " data"}, 32'(O_data), 32'(exp_frame[j]));
            chk({tag, " last"}, 32'(O_last), 32'(j == 7));
            got[j] = O_data;
            tick();
            if (j == 0) chk({tag, " err_clear"}, 32'(err), 32'd0);
        end
        chk({tag, " done_valid"}, 32'(O_valid), 32'd0);
        chk({tag, " idle_data"}, 32'(O_data), 32'd0);
        chk({tag, " T_hold"}, 32'(T), 32'(exp_frame));
        chk({tag, " frame"}, 32'(got), 32'(exp_frame));
        ones = 0;
        for (int b = 0; b < 8; b++) ones += int'(got[b]);
        chk({tag, " popcount"}, 32'(ones), 32'(exp_keff));
    endtask

    initial begin
        logic [7:0] bp_frame;
        int bp_cnt;
        int cyc;

        vecs[0]  = '{4'd0,  8'h00, 1'b0, 0};
        vecs[1]  = '{4'd1,  8'h01, 1'b0, 1};
        vecs[2]  = '{4'd2,  8'h03, 1'b0, 2};
        vecs[3]  = '{4'd3,  8'h07, 1'b0, 3};
        vecs[4]  = '{4'd4,  8'h0F, 1'b0, 4};
        vecs[5]  = '{4'd5,  8'h1F, 1'b0, 5};
        vecs[6]  = '{4'd6,  8'h3F, 1'b0, 6};
        vecs[7]  = '{4'd7,  8'h7F, 1'b0, 7};
        vecs[8]  = '{4'd8,  8'hFF, 1'b0, 8};
        vecs[9]  = '{4'd9,  OOR_FRAME, 1'b1, OOR_K};
        vecs[10] = '{4'd12, OOR_FRAME, 1'b1, OOR_K};
        vecs[11] = '{4'd15, OOR_FRAME, 1'b1, OOR_K};

        ASYNCRESETN = 1'b0;
        I = 4'd0;
        I_valid = 1'b0;
        O_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
        #1;
        chk("rst I_ready", 32'(I_ready), 32'd1);
        chk("rst O_valid", 32'(O_valid), 32'd0);
        chk("rst O_data", 32'(O_data), 32'd0);
        chk("rst O_last", 32'(O_last), 32'd0);
        chk("rst T", 32'(T), 32'h00);
        chk("rst err", 32'(err), 32'd0);

        // Order puts k=3 first to mirror the basic bring-up case.
        run_frame(vecs[3].k, vecs[3].frame, vecs[3].err, vecs[3].k_eff, "k3");
        for (int v = 0; v < 12; v++) begin
            run_frame(vecs[v].k, vecs[v].frame, vecs[v].err, vecs[v].k_eff, $sformatf("vec%0d", v));
        end

        // Back-to-back: 8 then 0, no bubble.
        O_ready = 1'b1;
        I = 4'd8;
        I_valid = 1'b1;
        tick();
        I = 4'd0;
        for (int j = 0; j < 16; j++) begin
            #1;
            chk("b2b valid", 32'(O_valid), 32'd1);
            chk("b2b data", 32'(O_data), 32'(j < 8));
            chk("b2b last", 32'(O_last), 32'(j == 7 || j == 15));
            if (j < 8) chk("b2b ready", 32'(I_ready), 32'(j == 7));
            tick();
            if (j == 7) begin
                I_valid = 1'b0;
                chk("b2b T2", 32'(T), 32'h00);
            end
        end
        chk("b2b end_valid", 32'(O_valid), 32'd0);

        // Backpressure on a k=5 frame; I changes mid-frame must be ignored.
        bp_frame = 8'h1F;
        O_ready = 1'b0;
        I = 4'd5;
        I_valid = 1'b1;
        tick();
        I_valid = 1'b0;
        I = 4'hF;
        bp_cnt = 0;
        cyc = 0;
        while (bp_cnt < 8 && cyc < 200) begin
            O_ready = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            chk("bp valid", 32'(O_valid), 32'd1);
            chk("bp data", 32'(O_data), 32'(bp_frame[bp_cnt]));
            chk("bp last", 32'(O_last), 32'(bp_cnt == 7));
            chk("bp ready", 32'(I_ready), 32'(O_ready && bp_cnt == 7));
            if (O_ready) bp_cnt++;
            tick();
            cyc++;
        end
        chk("bp completed", 32'(bp_cnt), 32'd8);
        chk("bp end_valid", 32'(O_valid), 32'd0);
        chk("bp T", 32'(T), 32'h1F);

        // Reset mid-frame after three beats.
        O_ready = 1'b1;
        I = 4'd6;
        I_valid = 1'b1;
        tick();
        I_valid = 1'b0;
        repeat (3) tick();
        chk("mrst pre_valid", 32'(O_valid), 32'd1);
        ASYNCRESETN = 1'b0;
        #1;
        chk("mrst O_valid", 32'(O_valid), 32'd0);
        chk("mrst T", 32'(T), 32'h00);
        chk("mrst O_data", 32'(O_data), 32'd0);
        chk("mrst I_ready", 32'(I_ready), 32'd1);
        #1;
        ASYNCRESETN = 1'b1;
        tick();
        chk("mrst no_resume", 32'(O_valid), 32'd0);
        run_frame(4'd2, 8'h03, 1'b0, 2, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
